// File: rtl/elevator_scan_ctrl.sv
// SCAN-policy (directional sweep) elevator controller with per-floor travel time and timed door dwell.
// Optional: define ELEVATOR_FIRE_RECALL_EN to add fire_recall (descend to floor 0, hold door open).
module elevator_scan_ctrl #(
    parameter int unsigned N_FLOORS      = 4,
    parameter int unsigned TRAVEL_CYCLES = 100000000,
    parameter int unsigned DOOR_CYCLES   = 50000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] floor,
`ifdef ELEVATOR_FIRE_RECALL_EN
    input  logic                fire_recall,
`endif
    output logic [N_FLOORS-1:0] y,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving,
    output logic                dir_up,
    output logic                door_open
);

    localparam int unsigned FW        = $clog2(N_FLOORS);
    localparam int unsigned TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TW        = $clog2(TIMER_MAX);

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
    localparam logic [FW-1:0] BOTTOM      = '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_DOOR_OPEN
    } state_e;

    state_e              state_q, state_d;
    logic [FW-1:0]       cur_q, cur_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                dir_up_q, dir_up_d;
    logic [N_FLOORS-1:0] pending_q, pending_d;

    logic [N_FLOORS-1:0] latch_mask;
    logic [N_FLOORS-1:0] clr_mask;
    logic [FW-1:0]       cur_up;
    logic [FW-1:0]       cur_dn;
    logic                above;
    logic                below;

    function automatic logic any_above(input logic [N_FLOORS-1:0] req,
                                       input logic [FW-1:0]       idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (i > int'(idx) && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic any_below(input logic [N_FLOORS-1:0] req,
                                       input logic [FW-1:0]       idx);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(N_FLOORS); i++) begin
            if (i < int'(idx) && req[i]) hit = 1'b1;
        end
        return hit;
    endfunction

    assign cur_up = cur_q + FW'(1);
    assign cur_dn = cur_q - FW'(1);
    assign above  = any_above(pending_q, cur_q);
    assign below  = any_below(pending_q, cur_q);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        timer_d    = timer_q;
        dir_up_d   = dir_up_q;
        latch_mask = floor;
        clr_mask   = '0;

        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (pending_q[cur_q]) begin
                    state_d         = S_DOOR_OPEN;
                    clr_mask[cur_q] = 1'b1;
                end else if (dir_up_q && above) begin
                    state_d = S_MOVE_UP;
                end else if (!dir_up_q && below) begin
                    state_d = S_MOVE_DOWN;
                end else if (above) begin
                    state_d  = S_MOVE_UP;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = S_MOVE_DOWN;
                    dir_up_d = 1'b0;
                end
            end

            S_MOVE_UP: begin
                if (timer_q == TRAVEL_LAST) begin
                    cur_d   = cur_up;
                    timer_d = '0;
                    if (pending_q[cur_up]) begin
                        state_d          = S_DOOR_OPEN;
                        clr_mask[cur_up] = 1'b1;
                    end else if (!any_above(pending_q, cur_up)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_MOVE_DOWN: begin
                if (timer_q == TRAVEL_LAST) begin
                    cur_d   = cur_dn;
                    timer_d = '0;
                    if (pending_q[cur_dn]) begin
                        state_d          = S_DOOR_OPEN;
                        clr_mask[cur_dn] = 1'b1;
                    end else if (!any_below(pending_q, cur_dn)) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_DOOR_OPEN: begin
                // A call for the floor we are standing at extends the dwell instead of queueing.
                latch_mask[cur_q] = 1'b0;
                if (floor[cur_q]) begin
                    timer_d = '0;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase

`ifdef ELEVATOR_FIRE_RECALL_EN
        if (fire_recall) begin
            latch_mask = '0;
            clr_mask   = '1;
            case (state_q)
                S_MOVE_UP: begin
                    // Finish the step already under way, then turn around.
                    state_d = S_MOVE_UP;
                    cur_d   = cur_q;
                    timer_d = timer_q + TW'(1);
                    if (timer_q == TRAVEL_LAST) begin
                        state_d  = S_MOVE_DOWN;
                        cur_d    = cur_up;
                        dir_up_d = 1'b0;
                        timer_d  = '0;
                    end
                end
                S_MOVE_DOWN: begin
                    state_d  = S_MOVE_DOWN;
                    cur_d    = cur_q;
                    dir_up_d = 1'b0;
                    timer_d  = timer_q + TW'(1);
                    if (timer_q == TRAVEL_LAST) begin
                        cur_d   = cur_dn;
                        timer_d = '0;
                        state_d = (cur_dn == BOTTOM) ? S_DOOR_OPEN : S_MOVE_DOWN;
                    end
                end
                default: begin
                    cur_d   = cur_q;
                    timer_d = '0;
                    if (cur_q != BOTTOM) begin
                        state_d  = S_MOVE_DOWN;
                        dir_up_d = 1'b0;
                    end else begin
                        state_d  = S_DOOR_OPEN;
                        dir_up_d = dir_up_q;
                    end
                end
            endcase
        end
`endif

        pending_d = (pending_q | latch_mask) & ~clr_mask;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            timer_q   <= '0;
            dir_up_q  <= 1'b1;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            timer_q   <= timer_d;
            dir_up_q  <= dir_up_d;
            pending_q <= pending_d;
        end
    end

    assign y         = N_FLOORS'(1) << cur_q;
    assign pending   = pending_q;
    assign moving    = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);
    assign dir_up    = dir_up_q;
    assign door_open = (state_q == S_DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl: directed timing scenarios plus random requests
// against a countdown-based behavioural model of the SCAN scheduling rules.
module tb_elevator_scan_ctrl;

    localparam int N = 4;
    localparam int T = 10;
    localparam int D = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] floor;
`ifdef ELEVATOR_FIRE_RECALL_EN
    logic         fire_recall;
`endif
    logic [N-1:0] y;
    logic [N-1:0] pending;
    logic         moving;
    logic         dir_up;
    logic         door_open;

    int errors = 0;
    int checks = 0;

    elevator_scan_ctrl #(
        .N_FLOORS     (N),
        .TRAVEL_CYCLES(T),
        .DOOR_CYCLES  (D)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .floor      (floor),
`ifdef ELEVATOR_FIRE_RECALL_EN
        .fire_recall(fire_recall),
`endif
        .y          (y),
        .pending    (pending),
        .moving     (moving),
        .dir_up     (dir_up),
        .door_open  (door_open)
    );

    always #5 clk = ~clk;

    // Behavioural model: the car is idle, travelling, or dwelling, with a countdown of cycles left.
    typedef enum {M_IDLE, M_TRAVEL, M_DOOR} act_e;
    act_e         m_act;
    int           m_cur;
    int           m_step;
    int           m_left;
    bit           m_up;
    bit [N-1:0]   m_pend;

    function automatic bit wanted_beyond(input bit [N-1:0] p, input int from, input int step);
        for (int fl = from + step; fl >= 0 && fl < N; fl += step)
            if (p[fl]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_act  = M_IDLE;
        m_cur  = 0;
        m_step = 1;
        m_left = 0;
        m_up   = 1'b1;
        m_pend = '0;
    endtask

    task automatic model_step(input logic [N-1:0] f);
        bit [N-1:0] take;
        bit [N-1:0] served;
        int         pref;
        take   = f;
        served = '0;
        case (m_act)
            M_IDLE: begin
                pref = m_up ? 1 : -1;
                if (m_pend[m_cur]) begin
                    served[m_cur] = 1'b1;
                    m_act  = M_DOOR;
                    m_left = D;
                end else if (wanted_beyond(m_pend, m_cur, pref)) begin
                    m_act  = M_TRAVEL;
                    m_step = pref;
                    m_left = T;
                end else if (wanted_beyond(m_pend, m_cur, -pref)) begin
                    m_act  = M_TRAVEL;
                    m_step = -pref;
                    m_left = T;
                    m_up   = !m_up;
                end
            end
            M_TRAVEL: begin
                m_left--;
                if (m_left == 0) begin
                    m_cur += m_step;
                    if (m_pend[m_cur]) begin
                        served[m_cur] = 1'b1;
                        m_act  = M_DOOR;
                        m_left = D;
                    end else if (wanted_beyond(m_pend, m_cur, m_step)) begin
                        m_left = T;
                    end else begin
                        m_act = M_IDLE;
                    end
                end
            end
            default: begin
                take[m_cur] = 1'b0;
                if (f[m_cur]) begin
                    m_left = D;
                end else begin
                    m_left--;
                    if (m_left == 0) m_act = M_IDLE;
                end
            end
        endcase
        m_pend = (m_pend | take) & ~served;
    endtask

    // One clock: drive request bits, let the edge happen, advance the model, sample at negedge.
    task automatic cycle(input logic [N-1:0] f);
        floor = f;
        @(posedge clk);
        model_step(f);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        floor = '0;
`ifdef ELEVATOR_FIRE_RECALL_EN
        fire_recall = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        cycle(4'b1000);
        repeat (3) cycle('0);
        rst_n = 1'b0;
        #1;
        checks++; if (y !== 4'b0001) begin errors++; $display("FAIL reset_y: got %b want 0001", y); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
        checks++; if (moving !== 1'b0) begin errors++; $display("FAIL reset_moving: got %b want 0", moving); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door: got %b want 0", door_open); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir_up: got %b want 1", dir_up); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_trip();
        logic [N-1:0] y_exp;
        logic         mov_exp;
        logic         door_exp;
        do_reset();
        cycle(4'b0100);
        for (int k = 1; k <= 27; k++) begin
            cycle('0);
            y_exp    = (k < 11) ? 4'b0001 : (k < 21) ? 4'b0010 : 4'b0100;
            mov_exp  = (k < 21);
            door_exp = (k >= 21) && (k < 26);
            checks++;
            if (y !== y_exp || moving !== mov_exp || door_open !== door_exp) begin
                errors++;
                $display("FAIL single_trip k=%0d: y=%b moving=%b door=%b, want y=%b moving=%b door=%b",
                         k, y, moving, door_open, y_exp, mov_exp, door_exp);
            end
        end
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL single_trip_pending: got %b want 0000", pending);
        end
    endtask

    task automatic test_sweep_order();
        logic [N-1:0] y_exp;
        logic [N-1:0] p_exp;
        logic         mov_exp;
        logic         door_exp;
        do_reset();
        cycle(4'b1010);
        for (int k = 1; k <= 45; k++) begin
            cycle('0);
            y_exp    = (k < 11) ? 4'b0001 : (k < 27) ? 4'b0010 : (k < 37) ? 4'b0100 : 4'b1000;
            p_exp    = (k < 11) ? 4'b1010 : (k < 37) ? 4'b1000 : 4'b0000;
            mov_exp  = (k < 11) || (k >= 17 && k < 37);
            door_exp = (k >= 11 && k < 16) || (k >= 37 && k < 42);
            checks++;
            if (y !== y_exp || pending !== p_exp || moving !== mov_exp || door_open !== door_exp) begin
                errors++;
                $display("FAIL sweep_order k=%0d: y=%b pend=%b moving=%b door=%b, want y=%b pend=%b moving=%b door=%b",
                         k, y, pending, moving, door_open, y_exp, p_exp, mov_exp, door_exp);
            end
        end
    endtask

    task automatic test_direction_hold();
        logic [N-1:0] y_exp;
        logic [N-1:0] p_exp;
        logic         mov_exp;
        logic         door_exp;
        logic         dir_exp;
        do_reset();
        cycle(4'b0100);
        repeat (26) cycle('0);
        cycle(4'b1000);
        for (int k = 1; k <= 52; k++) begin
            cycle((k == 5) ? 4'b0001 : 4'b0000);
            y_exp    = (k < 11) ? 4'b0100 : (k < 27) ? 4'b1000 : (k < 37) ? 4'b0100 :
                       (k < 47) ? 4'b0010 : 4'b0001;
            p_exp    = (k < 5) ? 4'b1000 : (k < 11) ? 4'b1001 : (k < 47) ? 4'b0001 : 4'b0000;
            mov_exp  = (k < 11) || (k >= 17 && k < 47);
            door_exp = (k >= 11 && k < 16) || (k >= 47 && k < 52);
            dir_exp  = (k < 17);
            checks++;
            if (y !== y_exp || pending !== p_exp || moving !== mov_exp ||
                door_open !== door_exp || dir_up !== dir_exp) begin
                errors++;
                $display("FAIL direction_hold k=%0d: y=%b pend=%b mov=%b door=%b dir=%b, want y=%b pend=%b mov=%b door=%b dir=%b",
                         k, y, pending, moving, door_open, dir_up, y_exp, p_exp, mov_exp, door_exp, dir_exp);
            end
        end
    endtask

    task automatic test_same_floor();
        logic [N-1:0] p_exp;
        logic         door_exp;
        do_reset();
        cycle(4'b0010);
        repeat (16) cycle('0);
        for (int k = 0; k <= 15; k++) begin
            cycle((k <= 8) ? 4'b0010 : 4'b0000);
            p_exp    = (k == 0) ? 4'b0010 : 4'b0000;
            door_exp = (k >= 1) && (k < 13);
            checks++;
            if (y !== 4'b0010 || pending !== p_exp || door_open !== door_exp || moving !== 1'b0) begin
                errors++;
                $display("FAIL same_floor k=%0d: y=%b pend=%b door=%b mov=%b, want y=0010 pend=%b door=%b mov=0",
                         k, y, pending, door_open, moving, p_exp, door_exp);
            end
        end
    endtask

    task automatic test_reset_mid_move();
        do_reset();
        cycle(4'b1000);
        repeat (22) cycle('0);
        checks++;
        if (y !== 4'b0100 || moving !== 1'b1 || pending !== 4'b1000) begin
            errors++;
            $display("FAIL mid_move_setup: y=%b moving=%b pend=%b, want y=0100 moving=1 pend=1000",
                     y, moving, pending);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (y !== 4'b0001 || pending !== 4'b0000 || moving !== 1'b0 ||
            door_open !== 1'b0 || dir_up !== 1'b1) begin
            errors++;
            $display("FAIL mid_move_reset: y=%b pend=%b mov=%b door=%b dir=%b, want 0001 0000 0 0 1",
                     y, pending, moving, door_open, dir_up);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [N-1:0]   f;
        logic [N-1:0]   my;
        logic [2*N+2:0] got;
        logic [2*N+2:0] exp;
        int             r;
        do_reset();
        f = '0;
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 15);
            if (r < 2) f = N'($urandom_range(1, (1 << N) - 1));
            else if (r != 2) f = '0;
            cycle(f);
            my        = '0;
            my[m_cur] = 1'b1;
            got = {y, pending, moving, dir_up, door_open};
            exp = {my, m_pend, m_act == M_TRAVEL, m_up, m_act == M_DOOR};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random i=%0d: y=%b pend=%b mov=%b dir=%b door=%b, model y=%b pend=%b mov=%b dir=%b door=%b",
                         i, y, pending, moving, dir_up, door_open,
                         my, m_pend, m_act == M_TRAVEL, m_up, m_act == M_DOOR);
            end
        end
    endtask

`ifdef ELEVATOR_FIRE_RECALL_EN
    task automatic test_fire_recall();
        logic [N-1:0] y_exp;
        logic         door_exp;
        logic         mov_exp;
        do_reset();
        cycle(4'b1000);
        repeat (31) cycle('0);
        cycle(4'b0010);
        fire_recall = 1'b1;
        cycle('0);
        checks++;
        if (pending !== 4'b0000 || moving !== 1'b1 || dir_up !== 1'b0 || y !== 4'b1000) begin
            errors++;
            $display("FAIL fire_start: pend=%b mov=%b dir=%b y=%b, want 0000 1 0 1000",
                     pending, moving, dir_up, y);
        end
        for (int k = 1; k <= 46; k++) begin
            fire_recall = (k <= 40);
            cycle((k == 5) ? 4'b0110 : 4'b0000);
            y_exp    = (k < 10) ? 4'b1000 : (k < 20) ? 4'b0100 : (k < 30) ? 4'b0010 : 4'b0001;
            door_exp = (k >= 30) && (k < 45);
            mov_exp  = (k < 30);
            checks++;
            if (y !== y_exp || door_open !== door_exp || moving !== mov_exp || pending !== 4'b0000) begin
                errors++;
                $display("FAIL fire_recall k=%0d: y=%b door=%b mov=%b pend=%b, want y=%b door=%b mov=%b pend=0000",
                         k, y, door_open, moving, pending, y_exp, door_exp, mov_exp);
            end
        end
        do_reset();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        floor = '0;
`ifdef ELEVATOR_FIRE_RECALL_EN
        fire_recall = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_trip();
        test_sweep_order();
        test_direction_hold();
        test_same_floor();
        test_reset_mid_move();
        test_random();
`ifdef ELEVATOR_FIRE_RECALL_EN
        test_fire_recall();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
